// File: rtl/jtkicker_romslot.sv
// jtkicker_romslot: byte-wide ROM slot responder with a one-word cache, filled over an SDRAM req/ack/rdy handshake
module jtkicker_romslot #(
    parameter int          AW     = 13,
    parameter logic [21:0] OFFSET = 22'h0,
    parameter int          SWAB   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          slot_cs,
    input  logic [AW-1:0] slot_addr,
    output logic [7:0]    slot_dout,
    output logic          slot_ok,
    output logic [21:0]   sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_rdy,
    input  logic [15:0]   sdram_din
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state, state_nx;
    logic          valid;
    logic [AW-2:0] tag, req_addr;
    logic [15:0]   word;
    logic          hit, fetch, fill, acked;

    assign hit        = valid && tag == slot_addr[AW-1:1];
    assign slot_ok    = slot_cs && hit;
    assign slot_dout  = (slot_addr[0] ^ (SWAB != 0)) ? word[15:8] : word[7:0];
    assign sdram_addr = OFFSET + 22'(req_addr);

    // next state; an ack and rdy landing together in REQ completes the fill in one step
    always_comb begin
        state_nx = state;
        fetch    = 1'b0;
        fill     = 1'b0;
        acked    = 1'b0;
        case (state)
            IDLE: begin
                fetch    = slot_cs && !hit;
                state_nx = fetch ? REQ : IDLE;
            end
            REQ: begin
                acked    = sdram_ack;
                fill     = sdram_ack && sdram_rdy;
                state_nx = fill ? IDLE : sdram_ack ? WAIT : REQ;
            end
            WAIT: begin
                fill     = sdram_rdy;
                state_nx = fill ? IDLE : WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // request latch and cache fill; reset invalidates so a stray rdy later has nothing to land in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= 1'b0;
            tag       <= '0;
            word      <= '0;
            req_addr  <= '0;
            sdram_req <= 1'b0;
        end else begin
            if (fetch) req_addr <= slot_addr[AW-1:1];
            sdram_req <= fetch ? 1'b1 : acked ? 1'b0 : sdram_req;
            if (fill) begin
                word  <= sdram_din;
                tag   <= req_addr;
                valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtkicker_romslot.sv
// tb_jtkicker_romslot: three slot instances (plain, byte-swapped, wrapping offset) against a transaction-level cache model
module tb_jtkicker_romslot;
    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        cs   = 1'b0;
    logic        ack  = 1'b0;
    logic        rdy  = 1'b0;
    logic [12:0] addr = '0;
    logic [15:0] din  = '0;
    logic [7:0]  dout  [3];
    logic        ok    [3];
    logic        req   [3];
    logic [21:0] saddr [3];
    int          checks   = 0;
    int          failures = 0;

    logic        m_valid = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_acked = 1'b0;
    logic [11:0] m_tag   = '0;
    logic [11:0] m_req   = '0;
    logic [15:0] m_word  = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        jtkicker_romslot #(
            .AW    (13),
            .OFFSET(g == 2 ? 22'h3FFFFF : 22'h010000),
            .SWAB  (g == 1 ? 1 : 0)
        ) u (
            .clk       (clk),
            .rst       (rst),
            .slot_cs   (cs),
            .slot_addr (addr),
            .slot_dout (dout[g]),
            .slot_ok   (ok[g]),
            .sdram_addr(saddr[g]),
            .sdram_req (req[g]),
            .sdram_ack (ack),
            .sdram_rdy (rdy),
            .sdram_din (din)
        );
    end

    function automatic logic [21:0] ofs(int i);
        return i == 2 ? 22'h3FFFFF : 22'h010000;
    endfunction

    function automatic logic [7:0] pick(int i, logic [15:0] w, logic a0);
        return (a0 ^ (i == 1)) ? w[15:8] : w[7:0];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_busy = 1'b0; m_acked = 1'b0;
        m_tag = '0; m_req = '0; m_word = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!m_busy) begin
            if (cs && !(m_valid && m_tag == addr[12:1])) begin
                m_busy = 1'b1; m_acked = 1'b0; m_req = addr[12:1];
            end
        end else if (m_acked ? rdy : (ack && rdy)) begin
            m_word = din; m_tag = m_req; m_valid = 1'b1; m_busy = 1'b0;
        end else if (ack) m_acked = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        cs = 1'b1; addr = 13'h0005;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ok[i] !== 1'b0) begin failures++; $display("FAIL reset_ok dut%0d got=%b exp=0", i, ok[i]); end
            checks++; if (dout[i] !== 8'h00) begin failures++; $display("FAIL reset_dout dut%0d got=%h exp=00", i, dout[i]); end
            checks++; if (req[i] !== 1'b0) begin failures++; $display("FAIL reset_req dut%0d got=%b exp=0", i, req[i]); end
            checks++; if (saddr[i] !== ofs(i)) begin failures++; $display("FAIL reset_saddr dut%0d got=%h exp=%h", i, saddr[i], ofs(i)); end
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_miss_basic();
        logic [7:0]  e [3];
        logic [21:0] a [3];
        e = '{8'hBE, 8'hEF, 8'hBE};
        a = '{22'h010002, 22'h010002, 22'h000001};
        #1;
        checks++; if (req[0] !== 1'b0) begin failures++; $display("FAIL miss_req_early got=%b exp=0", req[0]); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (req[i] !== 1'b1) begin failures++; $display("FAIL miss_req dut%0d got=%b exp=1", i, req[i]); end
            checks++; if (saddr[i] !== a[i]) begin failures++; $display("FAIL miss_saddr dut%0d got=%h exp=%h", i, saddr[i], a[i]); end
        end
        tick();
        checks++; if (req[0] !== 1'b1 || saddr[0] !== 22'h010002) begin failures++; $display("FAIL miss_req_hold got=%b/%h exp=1/010002", req[0], saddr[0]); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (req[0] !== 1'b0) begin failures++; $display("FAIL miss_req_drop got=%b exp=0", req[0]); end
        tick(); tick();
        rdy = 1'b1; din = 16'hBEEF; #1;
        checks++; if (ok[0] !== 1'b0) begin failures++; $display("FAIL miss_ok_before_rdy got=%b exp=0", ok[0]); end
        tick(); rdy = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ok[i] !== 1'b1) begin failures++; $display("FAIL miss_ok dut%0d got=%b exp=1", i, ok[i]); end
            checks++; if (dout[i] !== e[i]) begin failures++; $display("FAIL miss_dout dut%0d got=%h exp=%h", i, dout[i], e[i]); end
        end
    endtask

    task automatic test_hit();
        logic [7:0] e [3];
        e = '{8'hEF, 8'hBE, 8'hEF};
        addr = 13'h0004; #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ok[i] !== 1'b1) begin failures++; $display("FAIL hit_ok dut%0d got=%b exp=1", i, ok[i]); end
            checks++; if (dout[i] !== e[i]) begin failures++; $display("FAIL hit_dout dut%0d got=%h exp=%h", i, dout[i], e[i]); end
        end
        tick();
        checks++; if (req[0] !== 1'b0) begin failures++; $display("FAIL hit_no_req got=%b exp=0", req[0]); end
        addr = 13'h0005; #1;
        checks++; if (dout[1] !== 8'hEF) begin failures++; $display("FAIL hit_swab_odd got=%h exp=ef", dout[1]); end
    endtask

    task automatic test_addr_change();
        addr = 13'h0100; #1;
        checks++; if (ok[0] !== 1'b0) begin failures++; $display("FAIL chg_ok_miss got=%b exp=0", ok[0]); end
        tick();
        checks++; if (req[0] !== 1'b1 || saddr[0] !== 22'h010080) begin failures++; $display("FAIL chg_req1 got=%b/%h exp=1/010080", req[0], saddr[0]); end
        ack = 1'b1; tick(); ack = 1'b0;
        addr = 13'h0200; tick();
        din = 16'h1234; rdy = 1'b1; tick(); rdy = 1'b0; #1;
        checks++; if (ok[0] !== 1'b0) begin failures++; $display("FAIL chg_ok_stale got=%b exp=0", ok[0]); end
        checks++; if (req[0] !== 1'b0) begin failures++; $display("FAIL chg_idle_gap got=%b exp=0", req[0]); end
        addr = 13'h0100; #1;
        checks++; if (ok[0] !== 1'b1 || dout[0] !== 8'h34) begin failures++; $display("FAIL chg_old_tag got=%b/%h exp=1/34", ok[0], dout[0]); end
        addr = 13'h0200; #1;
        tick();
        checks++; if (req[0] !== 1'b1 || saddr[0] !== 22'h010100) begin failures++; $display("FAIL chg_req2 got=%b/%h exp=1/010100", req[0], saddr[0]); end
        checks++; if (saddr[2] !== 22'h0000FF) begin failures++; $display("FAIL chg_saddr_wrap got=%h exp=0000ff", saddr[2]); end
        ack = 1'b1; tick(); ack = 1'b0;
        din = 16'hCAFE; rdy = 1'b1; tick(); rdy = 1'b0; #1;
        checks++; if (ok[0] !== 1'b1 || dout[0] !== 8'hFE || dout[1] !== 8'hCA) begin failures++; $display("FAIL chg_fill2 got=%b/%h/%h exp=1/fe/ca", ok[0], dout[0], dout[1]); end
    endtask

    task automatic test_cs_low();
        cs = 1'b0; addr = 13'h0AAA;
        for (int n = 0; n < 20; n++) begin
            ack = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1)); din = 16'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++; if (req[i] !== 1'b0 || ok[i] !== 1'b0) begin failures++; $display("FAIL cslow_idle dut%0d cyc%0d got=%b/%b exp=0/0", i, n, req[i], ok[i]); end
            end
        end
        ack = 1'b0; rdy = 1'b0; cs = 1'b1; #1;
        checks++; if (req[0] !== 1'b0) begin failures++; $display("FAIL cslow_req_early got=%b exp=0", req[0]); end
        tick();
        checks++; if (req[0] !== 1'b1 || saddr[0] !== 22'h010555) begin failures++; $display("FAIL cslow_req got=%b/%h exp=1/010555", req[0], saddr[0]); end
        ack = 1'b1; tick(); ack = 1'b0;
        din = 16'h9A3C; rdy = 1'b1; tick(); rdy = 1'b0; #1;
        checks++; if (ok[0] !== 1'b1 || dout[0] !== 8'h3C) begin failures++; $display("FAIL cslow_fill got=%b/%h exp=1/3c", ok[0], dout[0]); end
    endtask

    task automatic test_async_reset();
        addr = 13'h0333; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        #2 rst = 1'b1; #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (req[i] !== 1'b0 || ok[i] !== 1'b0 || dout[i] !== 8'h00) begin failures++; $display("FAIL arst_outs dut%0d got=%b/%b/%h exp=0/0/00", i, req[i], ok[i], dout[i]); end
        end
        #1 rst = 1'b0; cs = 1'b0;
        din = 16'hFFFF; rdy = 1'b1; tick(); rdy = 1'b0;
        cs = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ok[i] !== 1'b0 || dout[i] !== 8'h00) begin failures++; $display("FAIL arst_stray dut%0d got=%b/%h exp=0/00", i, ok[i], dout[i]); end
        end
        tick();
        checks++; if (req[0] !== 1'b1 || saddr[0] !== 22'h010199) begin failures++; $display("FAIL arst_fresh_req got=%b/%h exp=1/010199", req[0], saddr[0]); end
        ack = 1'b1; tick(); ack = 1'b0;
        din = 16'h0F1E; rdy = 1'b1; tick(); rdy = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] e [3];
        e = '{8'hAA, 8'h55, 8'hAA};
        addr = 13'h0002; #1;
        checks++; if (ok[2] !== 1'b0) begin failures++; $display("FAIL wrap_ok_miss got=%b exp=0", ok[2]); end
        tick();
        checks++; if (req[2] !== 1'b1 || saddr[2] !== 22'h000000) begin failures++; $display("FAIL wrap_saddr got=%b/%h exp=1/000000", req[2], saddr[2]); end
        ack = 1'b1; rdy = 1'b1; din = 16'h55AA; tick(); ack = 1'b0; rdy = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ok[i] !== 1'b1 || dout[i] !== e[i] || req[i] !== 1'b0) begin failures++; $display("FAIL wrap_fill dut%0d got=%b/%h/%b exp=1/%h/0", i, ok[i], dout[i], req[i], e[i]); end
        end
        tick();
        checks++; if (req[2] !== 1'b0) begin failures++; $display("FAIL wrap_no_traffic got=%b exp=0", req[2]); end
    endtask

    task automatic test_back_to_back();
        logic        e_ok, e_req;
        logic [7:0]  e_dout;
        logic [21:0] e_addr;
        for (int n = 0; n < 400; n++) begin
            cs   = ($urandom_range(0, 7) != 0);
            addr = 13'h0040 + 13'($urandom_range(0, 7));
            ack  = ($urandom_range(0, 2) == 0);
            rdy  = ($urandom_range(0, 2) == 0);
            din  = 16'($urandom);
            #1;
            e_ok  = cs && m_valid && m_tag == addr[12:1];
            e_req = m_busy && !m_acked;
            for (int i = 0; i < 3; i++) begin
                e_dout = pick(i, m_word, addr[0]);
                e_addr = ofs(i) + {10'd0, m_req};
                checks++; if (ok[i] !== e_ok) begin failures++; $display("FAIL rnd_ok dut%0d cyc%0d got=%b exp=%b", i, n, ok[i], e_ok); end
                checks++; if (dout[i] !== e_dout) begin failures++; $display("FAIL rnd_dout dut%0d cyc%0d got=%h exp=%h", i, n, dout[i], e_dout); end
                checks++; if (req[i] !== e_req) begin failures++; $display("FAIL rnd_req dut%0d cyc%0d got=%b exp=%b", i, n, req[i], e_req); end
                checks++; if (saddr[i] !== e_addr) begin failures++; $display("FAIL rnd_saddr dut%0d cyc%0d got=%h exp=%h", i, n, saddr[i], e_addr); end
            end
            tick();
        end
        ack = 1'b0; rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_miss_basic();
        test_hit();
        test_addr_change();
        test_cs_low();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtkicker_romslot.md
Name: jtkicker_romslot

Overview:
Responder end of a game-core ROM port (`*_addr`/`*_cs`/`*_data`/`*_ok`). It serves 8-bit reads from a 16-bit SDRAM word and keeps a one-word cache. On a miss it fetches the word through a req/ack/rdy SDRAM handshake. One instance per ROM slot (main, scr, obj) sits between the game module and the SDRAM arbiter.

Parameters:
AW, 13, slot byte-address width (≥2)
OFFSET, 22'h0, SDRAM word offset of this slot's region
SWAB, 0, 0: byte addr[0]=0 → din[7:0]; 1: addr[0]=0 → din[15:8]

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
slot_cs  in  1  read request from game core
slot_addr  in  AW  byte address
slot_dout  out  8  read byte
slot_ok  out  1  slot_dout valid for current slot_addr
sdram_addr  out  22  word address = OFFSET + req_addr (22-bit wrap)
sdram_req  out  1  request to arbiter
sdram_ack  in  1  arbiter accepted request (1-cycle pulse)
sdram_rdy  in  1  sdram_din valid (1-cycle pulse)
sdram_din  in  16  read word

Behaviour:
- Cache: `valid` (1b), `tag` (AW-1 b), `word` (16b).
- `hit` = valid & (tag == slot_addr[AW-1:1]).
- Outputs are combinational from the cache:
  - slot_ok = slot_cs & hit.
  - slot_dout = byte of `word` selected by slot_addr[0] and SWAB.
  - slot_dout is don't-care when slot_ok=0, but is driven from `word`, never X after reset.
- Reset (async) clears valid, word=0, tag=0, req_addr=0, sdram_req=0, FSM=IDLE. Resulting outputs: slot_ok=0, slot_dout=0.
- FSM states IDLE, REQ, WAIT:
  - IDLE: if slot_cs & !hit, then req_addr<=slot_addr[AW-1:1], sdram_req<=1, go REQ. Otherwise stay in IDLE.
  - REQ: hold sdram_req=1 and sdram_addr stable until sdram_ack. On ack: sdram_req<=0, go WAIT.
  - WAIT: on sdram_rdy: word<=sdram_din, tag<=req_addr, valid<=1, go IDLE.
- sdram_ack and sdram_rdy in the same cycle while in REQ: treat as ack then rdy. Cache is filled, go IDLE.
- sdram_rdy outside WAIT (and not paired with ack in REQ): ignored.
- sdram_ack outside REQ: ignored.
- Latency on a miss:
  - sdram_req rises on edge 1 after slot_cs&miss is seen at edge 0.
  - slot_ok rises combinationally right after the edge that samples sdram_rdy, provided slot_addr still matches req_addr.
- Address change during REQ/WAIT: the transaction completes and the cache fills with req_addr's word. Nothing is aborted. The FSM then returns to IDLE and re-evaluates; a new miss issues the next request one edge later.
- slot_cs dropping mid-transaction: the transaction still completes and fills the cache.
- Back-to-back miss: at least one IDLE cycle between rdy and the next sdram_req rise. No request is issued while slot_cs=0.
- Hit while valid: no SDRAM traffic. Both bytes of the cached word are served with zero latency.
- Async reset mid-REQ/WAIT:
  - sdram_req drops immediately and the cache is invalidated.
  - A later stray rdy is ignored.
- sdram_addr = OFFSET + {0, req_addr}, computed mod 2^22.

Test Plan:
1. Reset, then slot_cs=1, addr=0x0005, OFFSET=0x10000, ack 2 cycles after req, rdy 3 cycles after ack with din=0xBEEF → sdram_addr=0x10002 while req=1; slot_ok=1, slot_dout=0xBE (SWAB=0) after rdy edge.
2. Following 1, addr=0x0004 → slot_ok=1 same cycle, slot_dout=0xEF, sdram_req stays 0. With SWAB=1 → 0xBE for addr 4, 0xEF for addr 5.
3. Miss on 0x0100; switch addr to 0x0200 while in WAIT; rdy with din=0x1234 → cache tag=0x080, slot_ok stays 0, new sdram_req for word 0x100 (+OFFSET) one edge after IDLE.
4. slot_cs=0 with uncached addr for 20 cycles → sdram_req never rises, slot_ok=0. Raise cs → req on next edge.
5. Assert rst during WAIT, release, then pulse rdy with din=0xFFFF → sdram_req=0 immediately, slot_ok=0, slot_dout=0, cache still invalid; next cs issues fresh req.
6. OFFSET=0x3FFFFF, addr=0x0002 → sdram_addr=0x000000 (wrap); ack and rdy in same cycle with din=0x55AA → slot_dout=0xAA after that edge.
